// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: checks VGA hsync/vsync timing against 640x480 and tracks lock.
// Optional scan-line probe enabled by defining VGA_PROBE_EN.
module vga_timing_monitor #(
    parameter int CLK_PER_PIX = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int LOCK_FRAMES = 2
`ifdef VGA_PROBE_EN
    ,
    parameter int PROBE_CLK   = 576,
    parameter int PROBE_LINE  = 35
`endif
) (
    input  logic        i_clk,
    input  logic        rst_btn,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [7:0]  vga_rgb,
    input  logic        err_clr,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        err_sticky,
    output logic [15:0] frame_cnt
`ifdef VGA_PROBE_EN
    ,
    output logic [7:0]  probe_rgb,
    output logic        probe_valid
`endif
);

    localparam logic [12:0] LINE_N = 13'(H_TOTAL * CLK_PER_PIX);
    localparam logic [11:0] HS_N   = 12'(H_SYNC * CLK_PER_PIX);
    localparam logic [10:0] VT_N   = 11'(V_TOTAL);
    localparam logic [10:0] VS_N   = 11'(V_SYNC);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state, state_n;

    logic hs_r, vs_r, hs_p, vs_p;
    logic smp_vld, smp_vld_p;
    logic edge_ok;
    logic hs_fall, hs_rise, vs_fall, vs_rise;

    logic [11:0] h_clk;
    logic [11:0] hs_w;
    logic [10:0] lines;
    logic [10:0] vs_w;
    logic        hs_seen, vs_seen;
    logic        arm_clr;
    logic        h_bad, v_bad;

    logic [7:0]  good, good_n, good_inc;
    logic        frame_err, frame_err_n;
    logic [15:0] cnt_n;
    logic        err_set;

    // Register the raw inputs once and keep the previous sample for edges.
    always_ff @(posedge i_clk) begin
        if (rst_btn) begin
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            hs_p      <= 1'b1;
            vs_p      <= 1'b1;
            smp_vld   <= 1'b0;
            smp_vld_p <= 1'b0;
        end else begin
            hs_r      <= vga_hs;
            vs_r      <= vga_vs;
            hs_p      <= hs_r;
            vs_p      <= vs_r;
            smp_vld   <= 1'b1;
            smp_vld_p <= smp_vld;
        end
    end

    // An edge needs two real samples; the reset value must not fake one.
    assign edge_ok = smp_vld_p;
    assign hs_fall = edge_ok & hs_p & ~hs_r;
    assign hs_rise = edge_ok & ~hs_p & hs_r;
    assign vs_fall = edge_ok & vs_p & ~vs_r;
    assign vs_rise = edge_ok & ~vs_p & vs_r;

    // Losing lock discards half-measured intervals, like a reset does.
    assign arm_clr = (state == ST_LOCKED) & (h_err | v_err);

    assign h_bad = ~arm_clr & hs_seen &
                   ((hs_fall & (({1'b0, h_clk} + 13'd1) != LINE_N)) |
                    (hs_rise & (hs_w != HS_N)));

    assign v_bad = ~arm_clr & vs_seen &
                   ((vs_fall & (lines != VT_N)) |
                    (vs_rise & (vs_w != VS_N)));

    // Saturating interval counters and the one-cycle-late error pulses.
    always_ff @(posedge i_clk) begin
        if (rst_btn) begin
            h_clk   <= '0;
            hs_w    <= '0;
            lines   <= '0;
            vs_w    <= '0;
            hs_seen <= 1'b0;
            vs_seen <= 1'b0;
            h_err   <= 1'b0;
            v_err   <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_clk <= '0;
            end else if (h_clk != 12'hFFF) begin
                h_clk <= h_clk + 12'd1;
            end

            if (hs_r) begin
                hs_w <= '0;
            end else if (hs_w != 12'hFFF) begin
                hs_w <= hs_w + 12'd1;
            end

            // A line starting with the vsync edge belongs to the new frame.
            if (vs_fall) begin
                lines <= {10'd0, hs_fall};
            end else if (hs_fall && lines != 11'h7FF) begin
                lines <= lines + 11'd1;
            end

            if (vs_r) begin
                vs_w <= '0;
            end else if (hs_fall && vs_w != 11'h7FF) begin
                vs_w <= vs_w + 11'd1;
            end

            if (arm_clr) begin
                hs_seen <= 1'b0;
                vs_seen <= 1'b0;
            end else begin
                if (hs_fall) hs_seen <= 1'b1;
                if (vs_fall) vs_seen <= 1'b1;
            end

            h_err <= h_bad;
            v_err <= v_bad;
        end
    end

    assign good_inc = good + 8'd1;

    // Lock acquisition: next state, clean-frame count and frame counter.
    always_comb begin
        state_n     = state;
        good_n      = good;
        frame_err_n = frame_err | h_bad | v_bad;
        cnt_n       = frame_cnt;
        unique case (state)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_n     = ST_TRACK;
                    good_n      = '0;
                    frame_err_n = 1'b0;
                end
            end
            ST_TRACK: begin
                if (vs_fall) begin
                    frame_err_n = 1'b0;
                    if (frame_err | h_bad | v_bad) begin
                        good_n = '0;
                    end else begin
                        good_n = good_inc;
                        if (good_inc >= LOCK_N) state_n = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (vs_fall) begin
                    cnt_n       = frame_cnt + 16'd1;
                    frame_err_n = 1'b0;
                end
                if (h_err | v_err) state_n = ST_SEARCH;
            end
            default: begin
                state_n = ST_SEARCH;
            end
        endcase
    end

    assign err_set = (state == ST_LOCKED) & (h_err | v_err);

    // State register plus the registered status outputs.
    always_ff @(posedge i_clk) begin
        if (rst_btn) begin
            state      <= ST_SEARCH;
            good       <= '0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
            frame_cnt  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state     <= state_n;
            good      <= good_n;
            frame_err <= frame_err_n;
            locked    <= (state_n == ST_LOCKED);
            frame_cnt <= cnt_n;
            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef VGA_PROBE_EN
    logic [7:0] rgb_r;
    logic       hit;

    assign hit = (state == ST_LOCKED) &
                 (lines == 11'(PROBE_LINE)) &
                 (h_clk == 12'(PROBE_CLK));

    // Register RGB alongside sync so the probe sees aligned pixels.
    always_ff @(posedge i_clk) begin
        if (rst_btn) begin
            rgb_r <= '0;
        end else begin
            rgb_r <= vga_rgb;
        end
    end

    // Capture one pixel per locked frame at the probe coordinate.
    always_ff @(posedge i_clk) begin
        if (rst_btn) begin
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            probe_valid <= hit;
            if (hit) probe_rgb <= rgb_r;
        end
    end
`else
    // RGB only feeds the probe; without it the pins are deliberately idle.
    logic unused_rgb;
    assign unused_rgb = ^vga_rgb;
`endif

endmodule
